// File: rtl/riscv_ahb_bus_sequencer.sv
// riscv_ahb_bus_sequencer
// Bus interface unit for a multi-cycle RISC-V core. Sequences the instruction
// fetch and the optional load/store of each instruction onto one AHB-Lite
// master port, with wait-state tolerance, byte/half/word lane handling and
// sticky error reporting (bus error response, timeout, misaligned access).
module riscv_ahb_bus_sequencer #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clock,
  input  logic                  reset,
  // core side
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic                  data_unsigned,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           instr,
  output logic                  pc_en,
  output logic                  wb_en,
  output logic [31:0]           data_rdata,
  output logic                  bus_error,
  // AHB-Lite master side
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [2:0] {
    FETCH_A,
    FETCH_D,
    EXEC,
    MEM_A,
    MEM_D,
    HALT
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Wait counter just wide enough to hold TIMEOUT+1 (its saturation value).
  localparam int             WCW         = $clog2(TIMEOUT + 2);
  localparam logic [WCW-1:0] WAIT_MAX    = WCW'(TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            bus_error_q, bus_error_d;

  logic [1:0]            htrans_c;
  logic [ADDR_WIDTH-1:0] haddr_c;
  logic                  timeout_hit;
  logic                  misaligned;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rdata_shifted;
  logic [31:0]           rdata_ext;

  // Access legality: halves on even addresses, words on 4-byte boundaries.
  always_comb begin
    unique case (data_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = data_addr[0];
      2'b10:   misaligned = |data_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Store data replicated onto every byte lane the slave might pick from.
  always_comb begin
    unique case (data_size)
      2'b00:   wdata_lanes = {4{data_wdata[7:0]}};
      2'b01:   wdata_lanes = {2{data_wdata[15:0]}};
      default: wdata_lanes = data_wdata;
    endcase
  end

  // Load result: move the addressed lane to bit 0, then sign/zero extend.
  always_comb begin
    rdata_shifted = HRDATA >> {data_addr[1:0], 3'b000};
    unique case (data_size)
      2'b00:   rdata_ext = data_unsigned ? {24'h0, rdata_shifted[7:0]}
                                         : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   rdata_ext = data_unsigned ? {16'h0, rdata_shifted[15:0]}
                                         : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: rdata_ext = rdata_shifted;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TIMEOUT_CNT);

  // Sequencer next state, bus address phase and core handshake pulses.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    instr_d  = instr_q;
    hwdata_d = hwdata_q;
    htrans_c = HTRANS_IDLE;
    haddr_c  = '0;
    HWRITE   = 1'b0;
    HSIZE    = HSIZE_WORD;
    pc_en    = 1'b0;
    wb_en    = 1'b0;
    unique case (state_q)
      FETCH_A: begin
        htrans_c = HTRANS_NONSEQ;
        haddr_c  = pc;
        if (HREADY) state_d = FETCH_D;
      end
      FETCH_D: begin
        if (HRESP) begin
          state_d = HALT;
        end else if (HREADY) begin
          instr_d = HRDATA;
          state_d = EXEC;
        end else if (timeout_hit) begin
          state_d = HALT;
        end
      end
      EXEC: begin
        if (!data_req) begin
          pc_en   = 1'b1;
          state_d = FETCH_A;
        end else if (misaligned) begin
          state_d = HALT;
        end else begin
          state_d = MEM_A;
        end
      end
      MEM_A: begin
        htrans_c = HTRANS_NONSEQ;
        haddr_c  = data_addr;
        HWRITE   = data_we;
        HSIZE    = {1'b0, data_size};
        if (HREADY) begin
          hwdata_d = wdata_lanes;
          state_d  = MEM_D;
        end
      end
      MEM_D: begin
        if (HRESP) begin
          state_d = HALT;
        end else if (HREADY) begin
          pc_en   = 1'b1;
          wb_en   = !data_we;
          state_d = FETCH_A;
        end else if (timeout_hit) begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Consecutive HREADY-low count within the current data phase.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == FETCH_D || state_q == MEM_D) && !HREADY
                 && wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Any entry into HALT is an error, and it stays flagged until reset.
  assign bus_error_d = bus_error_q | (state_d == HALT);

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH_A;
      instr_q     <= NOP_INSTR;
      hwdata_q    <= '0;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      instr_q     <= instr_d;
      hwdata_q    <= hwdata_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
    end
  end

  // NOTE: the reset state is FETCH_A so the first NONSEQ appears right after
  // reset releases; while reset is held the address phase is forced idle.
  assign HTRANS     = reset ? htrans_c : HTRANS_IDLE;
  assign HADDR      = reset ? haddr_c  : '0;
  assign HWDATA     = hwdata_q;
  assign instr      = instr_q;
  assign bus_error  = bus_error_q;
  assign data_rdata = wb_en ? rdata_ext : 32'h0;

endmodule

// File: doc/riscv_ahb_bus_sequencer.md
# riscv_ahb_bus_sequencer

- Multi-cycle bus interface unit for the RISC-V core.
- Replaces the separate single-cycle instruction/data read ports with one AHB-Lite master port, sequencing the instruction fetch and the optional load/store access of each instruction onto that port.
- Tolerates wait states, generates byte/half/word sizing and lane steering, and flags bus errors and timeouts.
- Sits between the core datapath (PC, register file, control unit) and the AHB-Lite interconnect shared with the UART.

## Interface
- ADDR_WIDTH, 32, address width of HADDR, pc and data_addr.
- TIMEOUT, 255, maximum consecutive HREADY-low cycles in one data phase; 0 disables the timeout.
- NOP_INSTR, 32'h00000013, instr value after reset and while no instruction is held.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_WIDTH  fetch address from the PC register.
- data_req  in  1  decoded instruction is a load/store; sampled in EXEC.
- data_we  in  1  1 = store, 0 = load.
- data_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- data_unsigned  in  1  zero-extend the load result (LBU/LHU).
- data_addr  in  ADDR_WIDTH  effective address (ALU result).
- data_wdata  in  32  store data (rs2).
- instr  out  32  held instruction register feeding decode.
- pc_en  out  1  one-cycle pulse; PC register loads its next value.
- wb_en  out  1  one-cycle pulse; load result valid, register file write allowed.
- data_rdata  out  32  extended load result, valid while wb_en = 1.
- bus_error  out  1  sticky; HRESP error, timeout, or misaligned/illegal access.
- HADDR  out  ADDR_WIDTH  AHB address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ only.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  {0, data_size} for data, 010 for fetch.
- HWDATA  out  32  lane-replicated store data, registered at address-phase acceptance.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB error response.

## Operation
FSM states: FETCH_A, FETCH_D, EXEC, MEM_A, MEM_D, HALT.

- **FETCH_A**: HTRANS=NONSEQ, HADDR=pc, HWRITE=0, HSIZE=010. HREADY=1 → FETCH_D; otherwise hold all outputs.
- **FETCH_D**: HTRANS=IDLE. On HREADY=1, latch instr ← HRDATA → EXEC.
- **EXEC**: decode is valid from instr.
  - data_req=0: pulse pc_en → FETCH_A.
  - data_req=1 and aligned (half needs addr[0]=0, word needs addr[1:0]=0, size ≠ 11) → MEM_A.
  - data_req=1 and misaligned or size=11: set bus_error → HALT, with no bus transfer.
- **MEM_A**: HTRANS=NONSEQ, HADDR=data_addr, HWRITE=data_we, HSIZE={0,data_size}. On HREADY=1, register HWDATA → MEM_D. HWDATA lanes:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- **MEM_D**: HTRANS=IDLE; HWDATA held. On HREADY=1:
  - Load: extract the byte/half at addr[1:0] from HRDATA, sign- or zero-extend per data_unsigned, pulse wb_en.
  - Load or store: pulse pc_en → FETCH_A.
- **Errors**: HRESP=1 in FETCH_D or MEM_D (either AHB error cycle) → bus_error=1 → HALT. HREADY low for more than TIMEOUT consecutive cycles in FETCH_D or MEM_D → same.
- **HALT**: HTRANS=IDLE, pc_en=0, wb_en=0 until reset.
- data_addr, data_req, data_we, data_size, data_unsigned and data_wdata must stay stable from EXEC through MEM_D. Instr is held, so this holds by construction.

## Timing
- Reset values:
  - state FETCH_A
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0
  - instr=NOP_INSTR, pc_en=0, wb_en=0, data_rdata=0, bus_error=0
  - wait counter=0
- First NONSEQ appears in the first clock after reset deasserts.
- Zero-wait non-memory instruction: 3 cycles (FETCH_A, FETCH_D, EXEC). pc_en pulses in EXEC.
- Zero-wait load/store: 5 cycles. wb_en and pc_en pulse together in MEM_D.
- Each HREADY-low cycle adds exactly one cycle. The address phase is held stable while HREADY=0.
- Wait counter clears on every state change and saturates at TIMEOUT+1.
- Reset asserted in any state, mid-transfer included: outputs take reset values immediately (asynchronously). No partial write-back or pc_en is issued.
- pc_en and wb_en are never high for more than one cycle, and never high in HALT.

## Test plan
- **Reset, then zero-wait fetch.** pc=0x0, HRDATA=0x00500093, data_req=0. Expect NONSEQ in cycles 1 and 4, instr=0x00500093 from cycle 3, pc_en high only in cycle 3.
- **Store byte.** data_addr=0x103, data_wdata=0x000000AB, data_size=00. Expect HSIZE=000, HWRITE=1, HWDATA=0xABABABAB in MEM_D, pc_en with no wb_en.
- **Signed load half.** data_addr=0x102, HRDATA=0x80010000. Expect data_rdata=0xFFFF8001. With data_unsigned=1, expect 0x00008001, with wb_en and pc_en single-cycle.
- **Wait states on fetch.** HREADY low for 3 cycles in FETCH_D. Expect HADDR/HTRANS held, EXEC and pc_en delayed by exactly 3 cycles.
- **Errors.**
  - HRESP=1 during a store data phase: expect bus_error=1 sticky, HTRANS=IDLE afterwards, no further pc_en.
  - Word load at 0x102: expect bus_error with no NONSEQ issued.
  - With TIMEOUT=4, HREADY stuck low: expect bus_error after 5 low cycles.
- **Reset mid-access.** Reset asserted in MEM_D of a load. Expect all outputs at reset values immediately, no wb_en, and a fresh fetch at the post-reset pc.
